// File: rtl/ctrl_pipe.sv
// ctrl_pipe: ID/EX, EX/MEM, MEM/WB control registers with
// load-use stall, EX branch resolve/flush and ALU forwarding selects.
module ctrl_pipe (
  input  logic       i_cp_clk,
  input  logic       i_cp_rst,
  input  logic       i_cp_valid,
  input  logic       i_cp_regdst,
  input  logic       i_cp_branch,
  input  logic       i_cp_memread,
  input  logic       i_cp_memtoreg,
  input  logic       i_cp_memwrite,
  input  logic       i_cp_alusrc,
  input  logic       i_cp_regwrite,
  input  logic [1:0] i_cp_aluop,
  input  logic [4:0] i_cp_rs,
  input  logic [4:0] i_cp_rt,
  input  logic [4:0] i_cp_rd,
  input  logic       i_cp_zero,
  output logic       o_cp_ex_regdst,
  output logic       o_cp_ex_alusrc,
  output logic [1:0] o_cp_ex_aluop,
  output logic       o_cp_mem_memread,
  output logic       o_cp_mem_memwrite,
  output logic       o_cp_wb_memtoreg,
  output logic       o_cp_wb_regwrite,
  output logic [4:0] o_cp_wb_wreg,
  output logic [1:0] o_cp_fwd_a,
  output logic [1:0] o_cp_fwd_b,
  output logic       o_cp_stall,
  output logic       o_cp_flush,
  output logic       o_cp_pcsrc
);

  typedef struct packed {
    logic       regdst;
    logic       branch;
    logic       memread;
    logic       memtoreg;
    logic       memwrite;
    logic       alusrc;
    logic       regwrite;
    logic [1:0] aluop;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
  } id_ex_t;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] wreg;
  } ex_mem_t;

  typedef struct packed {
    logic       regwrite;
    logic       memtoreg;
    logic [4:0] wreg;
  } mem_wb_t;

  id_ex_t  id_ex;
  id_ex_t  id_next;
  ex_mem_t ex_mem;
  mem_wb_t mem_wb;

  logic [4:0] ex_wreg;
  logic       taken;
  logic       rt_used;
  logic       rs_hit;
  logic       rt_hit;

  // Priority forwarding select for one EX operand register.
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input ex_mem_t    em,
    input mem_wb_t    mw
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (em.regwrite && em.wreg != 5'd0 && em.wreg == src)
      sel = 2'b10;
    else if (mw.regwrite && mw.wreg != 5'd0 && mw.wreg == src)
      sel = 2'b01;
    return sel;
  endfunction

  // EX-stage destination, branch outcome and hazard terms.
  always_comb begin
    ex_wreg = id_ex.regdst ? id_ex.rd : id_ex.rt;
    taken   = id_ex.branch &
              (i_cp_zero ^ (id_ex.aluop == 2'b11));
    rt_used = ~i_cp_alusrc | i_cp_memwrite | i_cp_branch;
    rs_hit  = ex_wreg == i_cp_rs;
    rt_hit  = (ex_wreg == i_cp_rt) & rt_used;
    o_cp_stall = id_ex.memread & (ex_wreg != 5'd0) &
                 (rs_hit | rt_hit) & i_cp_valid & ~taken;
    o_cp_flush = taken;
    o_cp_pcsrc = taken;
    o_cp_fwd_a = fwd_sel(id_ex.rs, ex_mem, mem_wb);
    o_cp_fwd_b = fwd_sel(id_ex.rt, ex_mem, mem_wb);
  end

  // Next ID/EX content: the ID bundle, or a bubble.
  always_comb begin
    id_next = '0;
    if (i_cp_valid && !o_cp_stall && !o_cp_flush) begin
      id_next.regdst   = i_cp_regdst;
      id_next.branch   = i_cp_branch;
      id_next.memread  = i_cp_memread;
      id_next.memtoreg = i_cp_memtoreg;
      id_next.memwrite = i_cp_memwrite;
      id_next.alusrc   = i_cp_alusrc;
      id_next.regwrite = i_cp_regwrite;
      id_next.aluop    = i_cp_aluop;
      id_next.rs       = i_cp_rs;
      id_next.rt       = i_cp_rt;
      id_next.rd       = i_cp_rd;
    end
  end

  // Stage registers; reset drops every in-flight instruction.
  always_ff @(posedge i_cp_clk) begin
    if (i_cp_rst) begin
      id_ex  <= '0;
      ex_mem <= '0;
      mem_wb <= '0;
    end else begin
      id_ex           <= id_next;
      ex_mem.memread  <= id_ex.memread;
      ex_mem.memwrite <= id_ex.memwrite;
      ex_mem.regwrite <= id_ex.regwrite;
      ex_mem.memtoreg <= id_ex.memtoreg;
      ex_mem.wreg     <= ex_wreg;
      mem_wb.regwrite <= ex_mem.regwrite;
      mem_wb.memtoreg <= ex_mem.memtoreg;
      mem_wb.wreg     <= ex_mem.wreg;
    end
  end

  // Stage outputs straight from the registers.
  always_comb begin
    o_cp_ex_regdst    = id_ex.regdst;
    o_cp_ex_alusrc    = id_ex.alusrc;
    o_cp_ex_aluop     = id_ex.aluop;
    o_cp_mem_memread  = ex_mem.memread;
    o_cp_mem_memwrite = ex_mem.memwrite;
    o_cp_wb_memtoreg  = mem_wb.memtoreg;
    o_cp_wb_regwrite  = mem_wb.regwrite;
    o_cp_wb_wreg      = mem_wb.wreg;
  end

endmodule

// File: tb/tb_ctrl_pipe.sv
// tb_ctrl_pipe: directed checks of stage timing, stall,
// branch flush and forwarding for ctrl_pipe.
module tb_ctrl_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid;
  logic       regdst, branch, memread, memtoreg;
  logic       memwrite, alusrc, regwrite;
  logic [1:0] aluop;
  logic [4:0] rs, rt, rd;
  logic       zero;
  logic       ex_regdst, ex_alusrc;
  logic [1:0] ex_aluop;
  logic       mem_memread, mem_memwrite;
  logic       wb_memtoreg, wb_regwrite;
  logic [4:0] wb_wreg;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, flush, pcsrc;

  int n_chk = 0;
  int n_fail = 0;

  logic [19:0] outs;
  assign outs = {ex_regdst, ex_alusrc, ex_aluop,
                 mem_memread, mem_memwrite,
                 wb_memtoreg, wb_regwrite, wb_wreg,
                 fwd_a, fwd_b, stall, flush, pcsrc};

  logic [3:0] ex_bits;
  assign ex_bits = {ex_regdst, ex_alusrc, ex_aluop};

  always #5 clk = ~clk;

  ctrl_pipe dut (
    .i_cp_clk          (clk),
    .i_cp_rst          (rst),
    .i_cp_valid        (valid),
    .i_cp_regdst       (regdst),
    .i_cp_branch       (branch),
    .i_cp_memread      (memread),
    .i_cp_memtoreg     (memtoreg),
    .i_cp_memwrite     (memwrite),
    .i_cp_alusrc       (alusrc),
    .i_cp_regwrite     (regwrite),
    .i_cp_aluop        (aluop),
    .i_cp_rs           (rs),
    .i_cp_rt           (rt),
    .i_cp_rd           (rd),
    .i_cp_zero         (zero),
    .o_cp_ex_regdst    (ex_regdst),
    .o_cp_ex_alusrc    (ex_alusrc),
    .o_cp_ex_aluop     (ex_aluop),
    .o_cp_mem_memread  (mem_memread),
    .o_cp_mem_memwrite (mem_memwrite),
    .o_cp_wb_memtoreg  (wb_memtoreg),
    .o_cp_wb_regwrite  (wb_regwrite),
    .o_cp_wb_wreg      (wb_wreg),
    .o_cp_fwd_a        (fwd_a),
    .o_cp_fwd_b        (fwd_b),
    .o_cp_stall        (stall),
    .o_cp_flush        (flush),
    .o_cp_pcsrc        (pcsrc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_clr();
    valid    = 1'b1;
    regdst   = 1'b0;
    branch   = 1'b0;
    memread  = 1'b0;
    memtoreg = 1'b0;
    memwrite = 1'b0;
    alusrc   = 1'b0;
    regwrite = 1'b0;
    aluop    = 2'b00;
    rs       = 5'd0;
    rt       = 5'd0;
    rd       = 5'd0;
  endtask

  task automatic id_nop();
    id_clr();
    valid = 1'b0;
  endtask

  task automatic id_r(input logic [4:0] s, t, d);
    id_clr();
    regdst   = 1'b1;
    regwrite = 1'b1;
    aluop    = 2'b10;
    rs = s; rt = t; rd = d;
  endtask

  task automatic id_lw(input logic [4:0] s, t);
    id_clr();
    memread  = 1'b1;
    memtoreg = 1'b1;
    regwrite = 1'b1;
    alusrc   = 1'b1;
    rs = s; rt = t;
  endtask

  task automatic id_sw(input logic [4:0] s, t);
    id_clr();
    memwrite = 1'b1;
    alusrc   = 1'b1;
    rs = s; rt = t;
  endtask

  task automatic id_addi(input logic [4:0] s, t);
    id_clr();
    alusrc   = 1'b1;
    regwrite = 1'b1;
    rs = s; rt = t;
  endtask

  task automatic id_br(input logic [1:0] op,
                       input logic [4:0] s, t);
    id_clr();
    branch = 1'b1;
    aluop  = op;
    rs = s; rt = t;
  endtask

  task automatic id_rand();
    {valid, regdst, branch, memread, memtoreg} = 5'($urandom);
    {memwrite, alusrc, regwrite, aluop} = 5'($urandom);
    rs   = 5'($urandom);
    rt   = 5'($urandom);
    rd   = 5'($urandom);
    zero = 1'($urandom);
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    zero = 1'b0;
    id_nop();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    id_rand();
    tick();
    id_rand();
    @(negedge clk);
    n_chk++;
    if (outs !== 20'd0) begin
      n_fail++;
      $display("FAIL rst_cyc1: got %h want 0", outs);
    end
    tick();
    id_rand();
    @(negedge clk);
    n_chk++;
    if (outs !== 20'd0) begin
      n_fail++;
      $display("FAIL rst_cyc2: got %h want 0", outs);
    end
    tick();
    rst  = 1'b0;
    zero = 1'b0;
    id_r(5'd1, 5'd2, 5'd3);
    @(negedge clk);
    n_chk++;
    if (outs !== 20'd0) begin
      n_fail++;
      $display("FAIL rst_release: got %h want 0", outs);
    end
    tick();
    id_r(5'd4, 5'd5, 5'd6);
    valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ex_bits !== 4'b1010) begin
      n_fail++;
      $display("FAIL first_ex: got %b want 1010", ex_bits);
    end
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if (ex_bits !== 4'b0000) begin
      n_fail++;
      $display("FAIL invalid_bubble: got %b want 0000", ex_bits);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if ({wb_regwrite, wb_memtoreg, wb_wreg} !== 7'b10_00011) begin
      n_fail++;
      $display("FAIL first_wb: got %b want 1000011",
               {wb_regwrite, wb_memtoreg, wb_wreg});
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    id_lw(5'd1, 5'd8);
    tick();
    id_r(5'd1, 5'd2, 5'd9);
    tick();
    id_nop();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (outs !== 20'd0) begin
      n_fail++;
      $display("FAIL mid_rst: got %h want 0", outs);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if (wb_regwrite !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_wb: got %b want 0", wb_regwrite);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    id_lw(5'd1, 5'd8);
    tick();
    id_r(5'd8, 5'd10, 5'd9);
    @(negedge clk);
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL lu_stall: got %b want 1", stall);
    end
    tick();
    @(negedge clk);
    n_chk++;
    if ({stall, ex_bits, mem_memread} !== 6'b0_0000_1) begin
      n_fail++;
      $display("FAIL lu_bubble: got %b want 000001",
               {stall, ex_bits, mem_memread});
    end
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if ({ex_bits, fwd_a, fwd_b} !== 8'b1010_01_00) begin
      n_fail++;
      $display("FAIL lu_fwd: got %b want 10100100",
               {ex_bits, fwd_a, fwd_b});
    end
    n_chk++;
    if ({wb_memtoreg, wb_wreg} !== 6'b1_01000) begin
      n_fail++;
      $display("FAIL lu_wb: got %b want 101000",
               {wb_memtoreg, wb_wreg});
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    id_lw(5'd1, 5'd8);
    tick();
    id_sw(5'd1, 5'd8);
    @(negedge clk);
    n_chk++;
    if (stall !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_data_stall: got %b want 1", stall);
    end
    id_addi(5'd2, 5'd8);
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL addi_rt_dst: got %b want 0", stall);
    end
    id_r(5'd3, 5'd4, 5'd5);
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL indep_nostall: got %b want 0", stall);
    end
    id_r(5'd8, 5'd4, 5'd5);
    valid = 1'b0;
    #1;
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL invalid_nostall: got %b want 0", stall);
    end
    do_reset();
    id_lw(5'd1, 5'd0);
    tick();
    id_r(5'd0, 5'd0, 5'd5);
    @(negedge clk);
    n_chk++;
    if (stall !== 1'b0) begin
      n_fail++;
      $display("FAIL r0_nostall: got %b want 0", stall);
    end
  endtask

  task automatic test_ex_fwd();
    do_reset();
    id_r(5'd1, 5'd2, 5'd8);
    tick();
    id_r(5'd8, 5'd8, 5'd11);
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b1010) begin
      n_fail++;
      $display("FAIL ex_fwd: got %b want 1010", {fwd_a, fwd_b});
    end
    do_reset();
    id_r(5'd1, 5'd2, 5'd0);
    tick();
    id_r(5'd0, 5'd0, 5'd11);
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b0000) begin
      n_fail++;
      $display("FAIL r0_fwd: got %b want 0000", {fwd_a, fwd_b});
    end
  endtask

  task automatic test_fwd_priority();
    do_reset();
    id_r(5'd1, 5'd2, 5'd5);
    tick();
    id_r(5'd3, 5'd4, 5'd5);
    tick();
    id_r(5'd5, 5'd6, 5'd7);
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if ({fwd_a, fwd_b} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fwd_prio: got %b want 1000", {fwd_a, fwd_b});
    end
  endtask

  task automatic test_beq();
    do_reset();
    id_br(2'b01, 5'd1, 5'd2);
    tick();
    id_br(2'b01, 5'd3, 5'd4);
    zero = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({pcsrc, flush} !== 2'b11) begin
      n_fail++;
      $display("FAIL beq_taken: got %b want 11", {pcsrc, flush});
    end
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if ({ex_bits, pcsrc, flush} !== 6'b0) begin
      n_fail++;
      $display("FAIL beq_squash: got %b want 000000",
               {ex_bits, pcsrc, flush});
    end
    do_reset();
    id_br(2'b01, 5'd1, 5'd2);
    tick();
    id_r(5'd1, 5'd2, 5'd9);
    zero = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({pcsrc, flush} !== 2'b00) begin
      n_fail++;
      $display("FAIL beq_nt: got %b want 00", {pcsrc, flush});
    end
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if (ex_bits !== 4'b1010) begin
      n_fail++;
      $display("FAIL beq_nt_ex: got %b want 1010", ex_bits);
    end
  endtask

  task automatic test_bne();
    do_reset();
    id_br(2'b11, 5'd1, 5'd2);
    tick();
    id_nop();
    zero = 1'b1;
    @(negedge clk);
    n_chk++;
    if (pcsrc !== 1'b0) begin
      n_fail++;
      $display("FAIL bne_z1: got %b want 0", pcsrc);
    end
    zero = 1'b0;
    #1;
    n_chk++;
    if ({pcsrc, flush} !== 2'b11) begin
      n_fail++;
      $display("FAIL bne_z0: got %b want 11", {pcsrc, flush});
    end
    do_reset();
    id_br(2'b11, 5'd1, 5'd8);
    memread = 1'b1;
    tick();
    id_r(5'd8, 5'd3, 5'd9);
    zero = 1'b1;
    @(negedge clk);
    n_chk++;
    if ({stall, flush} !== 2'b10) begin
      n_fail++;
      $display("FAIL nt_stall: got %b want 10", {stall, flush});
    end
    zero = 1'b0;
    #1;
    n_chk++;
    if ({stall, flush} !== 2'b01) begin
      n_fail++;
      $display("FAIL flush_prio: got %b want 01", {stall, flush});
    end
    tick();
    id_nop();
    @(negedge clk);
    n_chk++;
    if (ex_bits !== 4'b0000) begin
      n_fail++;
      $display("FAIL flush_bubble: got %b want 0000", ex_bits);
    end
  endtask

  initial begin
    rst  = 1'b1;
    zero = 1'b0;
    id_nop();
    test_reset();
    test_reset_mid();
    test_load_use();
    test_back_to_back();
    test_ex_fwd();
    test_fwd_priority();
    test_beq();
    test_bne();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
